width_downsizer: RTL
====================

WIDTH_DOWNSIZER -- requirements
Module: width_downsizer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of one output beat.
REQ-002 Parameter RATIO, default 4, SHALL set the number of output beats per input word; legal range is 2..16.
REQ-003 i_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 i_rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 i_valid  input  1  SHALL indicate that the upstream word on i_data is valid.
REQ-006 o_ready  output  1  SHALL indicate that the block accepts an upstream word this cycle.
REQ-007 i_data  input  WIDTH*RATIO  SHALL carry the wide upstream word.
REQ-008 o_valid  output  1  SHALL indicate that the downstream beat on o_data is valid.
REQ-009 i_ready  input  1  SHALL indicate that downstream accepts the beat this cycle.
REQ-010 o_data  output  WIDTH  SHALL carry the current narrow beat.
REQ-011 o_last  output  1  SHALL mark the final beat of each word.

Function
REQ-012 An upstream transfer SHALL occur on a cycle with i_valid=1 and o_ready=1; a downstream transfer SHALL occur on a cycle with o_valid=1 and i_ready=1.
REQ-013 The FSM SHALL have two states: IDLE (holding no word) and SEND (holding a word).
REQ-014 In IDLE: o_ready=1 and o_valid=0; an upstream transfer SHALL capture i_data, clear the beat index to 0 and move the FSM to SEND.
REQ-015 In SEND: o_valid=1; o_data SHALL equal word bits [idx*WIDTH +: WIDTH], sent LSB slice first; o_last SHALL equal (idx==RATIO-1).
REQ-016 In SEND, a downstream transfer with idx<RATIO-1 SHALL increment idx.
REQ-017 In SEND, a downstream transfer with idx==RATIO-1 SHALL return the FSM to IDLE, unless an upstream transfer occurs in the same cycle.
REQ-018 In SEND, o_ready SHALL equal (idx==RATIO-1 && i_ready), combinationally.
REQ-019 When a last-beat downstream transfer and an upstream transfer occur in the same cycle, the block SHALL capture the new word, clear idx to 0 and stay in SEND, leaving no bubble.
REQ-020 The first beat SHALL appear on the cycle after the upstream capture (latency 1).
REQ-021 Sustained throughput SHALL be exactly RATIO beats per word, with zero idle cycles when i_valid and i_ready are held at 1.
REQ-022 While i_ready=0 in SEND, o_data, o_last and idx SHALL hold stable and o_valid SHALL remain 1.
REQ-023 Input changes while o_ready=0 SHALL have no effect on the stored word.
REQ-024 The idx counter width SHALL be $clog2(RATIO); idx SHALL never exceed RATIO-1.

Reset
REQ-025 While i_rst_n=0: state=IDLE, idx=0, word register=0, o_valid=0, o_last=0, o_data=0, o_ready=0.
REQ-026 o_ready SHALL rise on the first cycle after reset deassertion.
REQ-027 Reset asserted mid-word SHALL discard the remaining beats immediately; no partial word SHALL be emitted after reset.

Structure
REQ-028 A shared package width_downsizer_pkg SHALL hold the FSM state enum (IDLE, SEND) and the default WIDTH and RATIO constants.
REQ-029 The block SHALL be one module with no sub-modules; the word register, idx counter and FSM SHALL be inline.
REQ-030 The block SHALL instantiate cleanly between two sample delay stages with matching widths (WIDTH*RATIO upstream, WIDTH downstream).

Verification (WIDTH=8, RATIO=4)
REQ-031 Single word: i_data=32'hDDCC_BBAA with i_valid for one cycle and i_ready=1 -> o_data AA, BB, CC, DD on 4 consecutive cycles starting at T+1, o_last only on DD, then o_ready=1.
REQ-032 Back-to-back: words 32'h0403_0201 and 32'h0807_0605 both offered with i_ready=1 -> beats 01..08 on 8 consecutive cycles, no gap, o_last on 04 and 08.
REQ-033 Backpressure: i_ready=0 for 3 cycles while beat BB is presented -> BB held stable with o_valid=1 and o_ready=0; sequence resumes with CC.
REQ-034 Mid-word reset: assert i_rst_n=0 after beat BB -> o_valid=0 immediately; after release o_ready=1 and no CC/DD beats appear.
REQ-035 Stall on last: i_ready=0 on DD while i_valid=1 -> o_ready=0 and the new word is not captured; when i_ready rises, the new word is captured the same cycle and its first beat follows on the next cycle.
REQ-036 Randomized i_valid/i_ready over 1000 words -> scoreboard matches every beat in order and counts exactly one o_last per word.

Source files
------------

// File: rtl/width_downsizer_pkg.sv
// Shared types and default geometry for the width downsizer.
package width_downsizer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_RATIO = 4;

endpackage

// File: rtl/width_downsizer.sv
// Splits one wide upstream word into RATIO narrow beats, LSB slice first,
// accepting the next word in the same cycle as the last beat so streams stay gapless.
module width_downsizer
  import width_downsizer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int RATIO = DEFAULT_RATIO
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [WIDTH*RATIO-1:0] i_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_last
);

  localparam int IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  state_e                      state_q, state_d;
  logic [RATIO-1:0][WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        isLast, upXfer, downXfer, sending;

  assign sending  = (state_q == SEND);
  assign isLast   = (idx_q == LAST_IDX);
  // o_ready is forced low while reset is held, even though the state is already IDLE.
  assign o_ready  = i_rst_n && (!sending || (isLast && i_ready));
  assign o_valid  = sending;
  assign o_last   = sending && isLast;
  assign o_data   = word_q[idx_q];
  assign upXfer   = i_valid && o_ready;
  assign downXfer = o_valid && i_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (upXfer) begin
          word_d  = i_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (downXfer) begin
          if (!isLast) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (upXfer) begin
            // Last beat leaves while the next word arrives: reload without a bubble.
            word_d = i_data;
            idx_d  = '0;
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

endmodule
